sat_counter: RTL and testbench

SAT_COUNTER -- requirements
Module: sat_counter

---
 rtl/sat_counter_pkg.sv | 15 +
 rtl/sat_counter.sv | 113 +++++++++++
 tb/tb_sat_counter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sat_counter_pkg.sv
// Shared types for the saturating/wrapping counter: bound-behaviour modes and
// the two-state control enum.
package sat_counter_pkg;

  typedef enum logic {
    MODE_LATCH = 1'b0,
    MODE_WRAP  = 1'b1
  } mode_e;

  typedef enum logic {
    RUN     = 1'b0,
    LATCHED = 1'b1
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Bounded up/down counter that either freezes at a bound (LATCH) or wraps to
// the opposite bound (WRAP), with clear, clamped parallel load and a step pulse.
//
// state   | meaning
// --------+-------------------------------------------------------------
// RUN     | counting normally; en steps the count toward up/down
// LATCHED | a bound was reached in LATCH mode; count frozen until clr/load/rst
module sat_counter
  import sat_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MIN_VAL = 0,
  parameter int unsigned MAX_VAL = (2**WIDTH) - 1,
  parameter mode_e       MODE    = MODE_LATCH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             latched,
  output logic             tick,
  output logic             at_max,
  output logic             at_min
);

  if (MIN_VAL >= MAX_VAL ||
      longint'(MAX_VAL) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_bounds
    $error("sat_counter: require MIN_VAL < MAX_VAL <= 2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] MIN_C = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  state_e           state_q;
  logic             tick_q;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_dec;

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
    if (v <= MIN_C) return MIN_C;
    if (v >= MAX_C) return MAX_C;
    return v;
  endfunction

  // Only used away from the bound they approach, so neither can overflow.
  assign count_inc = count_q + ONE;
  assign count_dec = count_q - ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= MIN_C;
      state_q <= RUN;
      tick_q  <= 1'b0;
    end else if (clr) begin
      count_q <= MIN_C;
      state_q <= RUN;
      tick_q  <= 1'b0;
    end else if (load) begin
      count_q <= clamp(load_val);
      state_q <= RUN;
      tick_q  <= 1'b0;
    end else if (en) begin
      tick_q <= 1'b0;
      if (MODE == MODE_WRAP) begin
        if (up) begin
          if (count_q == MAX_C) begin
            count_q <= MIN_C;
            tick_q  <= 1'b1;
          end else begin
            count_q <= count_inc;
          end
        end else begin
          if (count_q == MIN_C) begin
            count_q <= MAX_C;
            tick_q  <= 1'b1;
          end else begin
            count_q <= count_dec;
          end
        end
      end else if (state_q == RUN) begin
        // Reaching the bound, or pushing against one already held, latches.
        if (up) begin
          if (count_q == MAX_C || count_inc == MAX_C) begin
            state_q <= LATCHED;
            tick_q  <= 1'b1;
          end
          if (count_q != MAX_C) count_q <= count_inc;
        end else begin
          if (count_q == MIN_C || count_dec == MIN_C) begin
            state_q <= LATCHED;
            tick_q  <= 1'b1;
          end
          if (count_q != MIN_C) count_q <= count_dec;
        end
      end
    end else begin
      tick_q <= 1'b0;
    end
  end

  assign count   = count_q;
  assign latched = (state_q == LATCHED);
  assign tick    = tick_q;
  assign at_max  = (count_q == MAX_C);
  assign at_min  = (count_q == MIN_C);

endmodule

// File: tb/tb_sat_counter.sv
// Three counter configurations share one stimulus stream and are checked each
// cycle against an integer reference model, plus directed scenario checks.
module tb_sat_counter;
  import sat_counter_pkg::*;

  logic clk = 1'b0;
  logic rst, en, up, clr, load;
  logic [3:0] load_val;

  logic [2:0][3:0] cnt;
  logic [2:0] lat_o, tick_o, amax_o, amin_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Model configuration per instance: d0 = 0..9 latch, d1 = 2..5 wrap, d2 = 2..5 latch
  int m_min  [3] = '{0, 2, 2};
  int m_max  [3] = '{9, 5, 5};
  bit m_wrap [3] = '{0, 1, 0};
  int m_cnt  [3];
  bit m_lat  [3];
  bit m_tick [3];

  always #5 clk = ~clk;

  sat_counter #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(9), .MODE(MODE_LATCH)) d0 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt[0]), .latched(lat_o[0]), .tick(tick_o[0]),
    .at_max(amax_o[0]), .at_min(amin_o[0]));

  sat_counter #(.WIDTH(4), .MIN_VAL(2), .MAX_VAL(5), .MODE(MODE_WRAP)) d1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt[1]), .latched(lat_o[1]), .tick(tick_o[1]),
    .at_max(amax_o[1]), .at_min(amin_o[1]));

  sat_counter #(.WIDTH(4), .MIN_VAL(2), .MAX_VAL(5), .MODE(MODE_LATCH)) d2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt[2]), .latched(lat_o[2]), .tick(tick_o[2]),
    .at_max(amax_o[2]), .at_min(amin_o[2]));

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural rules: reset/clear to min, clamped load, bounded step semantics.
  task automatic model_step(input int k);
    int tgt;
    m_tick[k] = 1'b0;
    if (rst || clr) begin
      m_cnt[k] = m_min[k];
      m_lat[k] = 1'b0;
    end else if (load) begin
      m_cnt[k] = (int'(load_val) < m_min[k]) ? m_min[k] :
                 (int'(load_val) > m_max[k]) ? m_max[k] : int'(load_val);
      m_lat[k] = 1'b0;
    end else if (en) begin
      if (m_wrap[k]) begin
        if (up && m_cnt[k] == m_max[k]) begin
          m_cnt[k] = m_min[k]; m_tick[k] = 1'b1;
        end else if (!up && m_cnt[k] == m_min[k]) begin
          m_cnt[k] = m_max[k]; m_tick[k] = 1'b1;
        end else begin
          m_cnt[k] = m_cnt[k] + (up ? 1 : -1);
        end
      end else if (!m_lat[k]) begin
        tgt = up ? m_max[k] : m_min[k];
        if (m_cnt[k] != tgt) m_cnt[k] = m_cnt[k] + (up ? 1 : -1);
        if (m_cnt[k] == tgt) begin
          m_lat[k] = 1'b1; m_tick[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d%0d.count", k),   int'(cnt[k]),    m_cnt[k]);
      chk($sformatf("d%0d.latched", k), int'(lat_o[k]),  int'(m_lat[k]));
      chk($sformatf("d%0d.tick", k),    int'(tick_o[k]), int'(m_tick[k]));
      chk($sformatf("d%0d.at_max", k),  int'(amax_o[k]), int'(m_cnt[k] == m_max[k]));
      chk($sformatf("d%0d.at_min", k),  int'(amin_o[k]), int'(m_cnt[k] == m_min[k]));
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit u, input bit c,
                     input bit l, input int lv);
    rst = r; en = e; up = u; clr = c; load = l; load_val = 4'(lv);
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0; m_lat[k] = 1'b0; m_tick[k] = 1'b0;
    end
    @(negedge clk);

    // Reset state
    cyc(1, 1, 1, 1, 1, 7);
    chk("rst.d0.count", int'(cnt[0]), 0);
    chk("rst.d1.count", int'(cnt[1]), 2);
    chk("rst.d0.latched", int'(lat_o[0]), 0);

    // Count up to 9 and freeze, tick only on the 8->9 step
    for (int i = 1; i <= 12; i++) begin
      cyc(0, 1, 1, 0, 0, 0);
      chk("up.d0.tick", int'(tick_o[0]), int'(i == 9));
    end
    chk("up.d0.count", int'(cnt[0]), 9);
    chk("up.d0.latched", int'(lat_o[0]), 1);

    // Frozen against down steps, then clr re-arms
    repeat (3) cyc(0, 1, 0, 0, 0, 0);
    chk("frz.d0.count", int'(cnt[0]), 9);
    cyc(0, 0, 0, 1, 0, 0);
    chk("clr.d0.count", int'(cnt[0]), 0);
    chk("clr.d0.latched", int'(lat_o[0]), 0);
    cyc(0, 1, 1, 0, 0, 0);
    chk("rearm.d0.count", int'(cnt[0]), 1);

    // Clamped loads
    cyc(0, 0, 0, 0, 1, 15);
    chk("ld15.d1.count", int'(cnt[1]), 5);
    chk("ld15.d2.tick", int'(tick_o[2]), 0);
    chk("ld15.d2.latched", int'(lat_o[2]), 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("ld0.d1.count", int'(cnt[1]), 2);

    // Wrap at 5 -> 2 with one tick, then 2 -> 5 going down
    cyc(0, 0, 0, 0, 1, 5);
    cyc(0, 1, 1, 0, 0, 0);
    chk("wrap.d1.count", int'(cnt[1]), 2);
    chk("wrap.d1.tick", int'(tick_o[1]), 1);
    cyc(0, 1, 1, 0, 0, 0);
    chk("wrap2.d1.count", int'(cnt[1]), 3);
    chk("wrap2.d1.tick", int'(tick_o[1]), 0);
    cyc(0, 0, 0, 0, 1, 2);
    cyc(0, 1, 0, 0, 0, 0);
    chk("wrapdn.d1.count", int'(cnt[1]), 5);
    chk("wrapdn.d1.tick", int'(tick_o[1]), 1);

    // Priority: clr beats load and en; rst beats everything
    cyc(0, 1, 1, 1, 1, 7);
    chk("prio.d0.count", int'(cnt[0]), 0);
    cyc(0, 0, 0, 0, 1, 7);
    cyc(1, 1, 1, 1, 1, 7);
    chk("prio.rst.d0.count", int'(cnt[0]), 0);

    // Load at a bound, push against it: latch + tick; reset while latched
    cyc(0, 0, 0, 0, 1, 9);
    chk("ldmax.d0.tick", int'(tick_o[0]), 0);
    chk("ldmax.d0.latched", int'(lat_o[0]), 0);
    cyc(0, 1, 1, 0, 0, 0);
    chk("push.d0.latched", int'(lat_o[0]), 1);
    chk("push.d0.tick", int'(tick_o[0]), 1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rstlat.d0.count", int'(cnt[0]), 0);
    chk("rstlat.d0.tick", int'(tick_o[0]), 0);
    chk("rstlat.d0.latched", int'(lat_o[0]), 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 70,
          1'($urandom), $urandom_range(0, 99) < 4,
          $urandom_range(0, 99) < 8, int'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
